// File: rtl/muldiv_iter.sv
// Iterative RV M-extension multiply/divide unit.
// One bit per cycle: shift-add multiply on operand magnitudes and restoring
// division on magnitudes, with the sign fixed up when the result is registered.
// Divide-by-zero and signed overflow finish immediately without iterating.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;   // negate final product / quotient / remainder
  logic [XLEN-1:0] hi_q;    // mul: upper product, div: partial remainder
  logic [XLEN-1:0] lo_q;    // mul: multiplier/lower product, div: dividend/quotient
  logic [XLEN-1:0] opnd_q;  // mul: multiplicand magnitude, div: divisor magnitude

  // Operand decode for a newly presented op
  logic            s1_signed, s2_signed, src1_neg, src2_neg, neg_in;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Decode signedness, magnitudes and the immediate-result division cases
  always_comb begin
    s1_signed   = op[2] ? ~op[0] : (op[1:0] != 2'd3);
    s2_signed   = op[2] ? ~op[0] : ~op[1];
    src1_neg    = s1_signed & src1[XLEN-1];
    src2_neg    = s2_signed & src2[XLEN-1];
    mag1        = src1_neg ? -src1 : src1;
    mag2        = src2_neg ? -src2 : src2;
    // Remainder follows the dividend; everything else follows the sign product
    neg_in      = (op[2] & op[1]) ? src1_neg : (src1_neg ^ src2_neg);
    div_zero    = (src2 == '0);
    div_ovf     = ~op[0] & (src1 == MinInt) & (src2 == '1);
    special     = op[2] & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = op[1] ? src1 : '1;
    end else begin
      special_res = op[1] ? '0 : MinInt;
    end
  end

  // One iteration step plus the sign-corrected final result
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  // Datapath step: add-and-shift for mul, trial-subtract for div
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {hi_q, lo_q[XLEN-1]};
    if (op_q[2]) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        // Remainder stays below the divisor, so the low XLEN bits suffice
        hi_nx = rem_sh[XLEN-1:0] - opnd_q;
        lo_nx = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = rem_sh[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_q ? -hi_nx : hi_nx;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (op_q[1:0] != 2'd0) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  // Control FSM with registered handshake outputs and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= op;
            neg_q    <= neg_in;
            hi_q     <= '0;
            lo_q     <= op[2] ? mag1 : mag2;
            opnd_q   <= op[2] ? mag2 : mag1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q   <= CNT_W'(XLEN);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result    <= final_res;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter (XLEN=32): a driver issues ops, the
// scoreboard records expected results from an arithmetic reference model at
// each accepted handshake and checks flags, latency and result every cycle.
module tb_muldiv_iter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  muldiv_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: plain 64-bit arithmetic following the RISC-V M rules
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pv;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    pv = p;
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return pv[63:32];
    return pv[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  logic sb_en = 1'b0;
  logic after_rst = 1'b1;
  int   lat;
  logic exp_ov;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  always @(posedge clk) edge_n++;

  // Consumer side back-pressure
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: check the current cycle against the model, then advance the model
  always @(negedge clk) begin
    if (sb_en) begin
      exp_ov = 1'b0;
      if (q.size() == 0) begin
        chk("idle_flags", {61'd0, in_ready, busy, out_valid}, 64'b100);
      end else begin
        lat    = edge_n - q[0].acc_edge;
        exp_ov = (lat >= q[0].lat);
        chk("busy_flags", {61'd0, in_ready, busy, out_valid}, {61'd0, 2'b01, exp_ov});
        if (exp_ov) chk("result", {32'd0, result}, {32'd0, q[0].res});
      end
      if (after_rst) begin
        chk("reset_result", {32'd0, result}, 64'd0);
        after_rst = 1'b0;
      end
      if (rst) begin
        q.delete();
        after_rst = 1'b1;
      end else if (flush) begin
        q.delete();
      end else if (q.size() != 0) begin
        if (exp_ov && out_ready) void'(q.pop_front());
      end else if (in_valid) begin
        q.push_back('{res: ref_res(op, src1, src2), lat: ref_lat(op, src1, src2),
                      acc_edge: edge_n + 1});
      end
    end
  end

  // Present one op and hold it until accepted, then scramble the inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op       = f;
    src1     = a;
    src2     = b;
    n        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    src1     = $urandom;
    src2     = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    sb_en = 1'b1;

    // Directed values, always-ready consumer
    for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i]);

    // Stalled consumer: result must hold for 10 cycles with in_ready low
    ready_mode = 2;
    issue(3'd0, 32'd123, 32'd456);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    repeat (10) @(negedge clk);
    ready_mode = 0;
    issue(3'd5, 32'd1000, 32'd7);
    issue(3'd7, 32'd1000, 32'd7);
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);

    // Flush mid-division, five cycles after acceptance
    issue(3'd4, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (3) @(posedge clk);

    // Flush together with in_valid in idle: op must not be accepted
    #1;
    in_valid = 1'b1;
    op       = 3'd0;
    src1     = 32'd3;
    src2     = 32'd4;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);

    // Flush while holding a result in DONE
    ready_mode = 2;
    issue(3'd4, 32'd5, 32'd0);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    ready_mode = 0;

    // Reset in the middle of a multiply
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized ops with random back-pressure and occasional flushes
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    end
    ready_mode = 0;

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
